mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported word memory with registered responses.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating arbitration; default is data-priority with a fetch starvation limit.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    input  logic        if_resp_ready,
    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic        d_resp_err,
    output logic [31:0] d_resp_rdata,
    input  logic        d_resp_ready,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    logic        if_wait, d_wait, gnt_f, gnt_d, d_aligned;
    logic        if_resp_valid_q, if_resp_valid_d;
    logic [31:0] if_resp_data_q, if_resp_data_d;
    logic        d_resp_valid_q, d_resp_valid_d;
    logic        d_resp_err_q, d_resp_err_d;
    logic [31:0] d_resp_rdata_q, d_resp_rdata_d;

    // A port may compete only if its response slot is free (or freeing) this cycle.
    assign if_wait   = if_req_valid & (~if_resp_valid_q | if_resp_ready);
    assign d_wait    = d_req_valid & (~d_resp_valid_q | d_resp_ready);
    assign d_aligned = (d_req_addr[1:0] == 2'b00);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;  // 0 = fetch has the turn, 1 = data

    always_comb begin
        gnt_f = 1'b0;
        gnt_d = 1'b0;
        ptr_d = ptr_q;
        if (!rst) begin
            if (if_wait && d_wait) begin
                gnt_d = ptr_q;
                gnt_f = ~ptr_q;
            end else begin
                gnt_f = if_wait;
                gnt_d = d_wait;
            end
        end
        if (gnt_f)      ptr_d = 1'b1;
        else if (gnt_d) ptr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_q, starve_d;
    logic          starved;

    // Counts data grants taken while fetch sat waiting; any other cycle clears it.
    always_comb begin
        starved  = if_wait && (starve_q >= CW'(STARVE_LIMIT));
        gnt_d    = !rst && d_wait && !starved;
        gnt_f    = !rst && if_wait && !gnt_d;
        starve_d = (gnt_d && if_wait) ? starve_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`endif

    assign if_req_ready = gnt_f;
    assign d_req_ready  = gnt_d;

    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        if (gnt_f) begin
            mem_address = if_req_addr;
        end else if (gnt_d && d_aligned) begin
            mem_address = d_req_addr;
            if (d_req_we) begin
                mem_write_data   = d_req_wdata;
                mem_write_enable = 1'b1;
            end
        end
    end

    always_comb begin
        if_resp_valid_d = if_resp_valid_q & ~if_resp_ready;
        if_resp_data_d  = if_resp_data_q;
        d_resp_valid_d  = d_resp_valid_q & ~d_resp_ready;
        d_resp_err_d    = d_resp_err_q;
        d_resp_rdata_d  = d_resp_rdata_q;
        if (gnt_f) begin
            if_resp_valid_d = 1'b1;
            if_resp_data_d  = mem_read_data;
        end
        if (gnt_d) begin
            d_resp_valid_d = 1'b1;
            d_resp_err_d   = ~d_aligned;
            d_resp_rdata_d = (d_aligned && !d_req_we) ? mem_read_data : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_resp_valid_q <= 1'b0;
            if_resp_data_q  <= '0;
            d_resp_valid_q  <= 1'b0;
            d_resp_err_q    <= 1'b0;
            d_resp_rdata_q  <= '0;
        end else begin
            if_resp_valid_q <= if_resp_valid_d;
            if_resp_data_q  <= if_resp_data_d;
            d_resp_valid_q  <= d_resp_valid_d;
            d_resp_err_q    <= d_resp_err_d;
            d_resp_rdata_q  <= d_resp_rdata_d;
        end
    end

    assign if_resp_valid = if_resp_valid_q;
    assign if_resp_data  = if_resp_data_q;
    assign d_resp_valid  = d_resp_valid_q;
    assign d_resp_err    = d_resp_err_q;
    assign d_resp_rdata  = d_resp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded random + directed bench for mem_arbiter; expected responses come from a shadow word memory.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0, if_resp_ready = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        d_req_valid = 1'b0, d_req_we = 1'b0, d_resp_ready = 1'b0;
    logic [31:0] d_req_addr = '0, d_req_wdata = '0;
    logic        if_req_ready, if_resp_valid, d_req_ready, d_resp_valid, d_resp_err, mem_write_enable;
    logic [31:0] if_resp_data, d_resp_rdata, mem_address, mem_write_data, mem_read_data;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem    [0:63];
    logic [31:0] shadow [0:63];
    logic [31:0] ifq[$];
    logic [32:0] dq[$];
    byte         gseq[$];

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_ready(if_resp_ready),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_err(d_resp_err), .d_resp_rdata(d_resp_rdata),
        .d_resp_ready(d_resp_ready),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, write on the clock edge.
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk) if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] fa, input logic dv, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd, input logic fr, input logic dr);
        @(posedge clk); #1;
        if_req_valid = fv; if_req_addr = fa; if_resp_ready = fr;
        d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd; d_resp_ready = dr;
    endtask

    // Monitor / scoreboard
    logic fg, dg, exp_we;
    always @(negedge clk) begin
        if (rst) begin
            ifq.delete();
            dq.delete();
            chk("rst_if_ready", {32'd0, if_req_ready}, 33'd0);
            chk("rst_d_ready", {32'd0, d_req_ready}, 33'd0);
            chk("rst_mem_we", {32'd0, mem_write_enable}, 33'd0);
            chk("rst_resp_valid", {31'd0, if_resp_valid, d_resp_valid}, 33'd0);
        end else begin
            fg = if_req_valid && if_req_ready;
            dg = d_req_valid && d_req_ready;
            chk("one_grant", {32'd0, fg && dg}, 33'd0);
            chk("if_latency", {32'd0, ifq.size() != 0 && !if_resp_valid}, 33'd0);
            chk("d_latency", {32'd0, dq.size() != 0 && !d_resp_valid}, 33'd0);
            if (if_resp_valid) begin
                if (ifq.size() == 0) chk("if_spurious", {32'd0, if_resp_valid}, 33'd0);
                else begin
                    chk("if_resp", {1'b0, if_resp_data}, {1'b0, ifq[0]});
                    if (if_resp_ready) void'(ifq.pop_front());
                    else chk("if_elig", {32'd0, if_req_ready}, 33'd0);
                end
            end
            if (d_resp_valid) begin
                if (dq.size() == 0) chk("d_spurious", {32'd0, d_resp_valid}, 33'd0);
                else begin
                    chk("d_resp", {d_resp_err, d_resp_rdata}, dq[0]);
                    if (d_resp_ready) void'(dq.pop_front());
                    else chk("d_elig", {32'd0, d_req_ready}, 33'd0);
                end
            end
            exp_we = dg && d_req_we && (d_req_addr[1:0] == 2'b00);
            chk("mem_we", {32'd0, mem_write_enable}, {32'd0, exp_we});
            if (fg) ifq.push_back(shadow[if_req_addr[7:2]]);
            if (dg) begin
                if (d_req_addr[1:0] != 2'b00) dq.push_back({1'b1, 32'd0});
                else if (d_req_we) begin
                    shadow[d_req_addr[7:2]] = d_req_wdata;
                    dq.push_back(33'd0);
                end else dq.push_back({1'b0, shadow[d_req_addr[7:2]]});
            end
        end
    end

    int          dcount;
    logic [31:0] keep;
    byte         expg;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            shadow[i] = mem[i];
        end
        mem[0] = 32'hDEADBEEF;
        shadow[0] = 32'hDEADBEEF;

        // Reset: requests present but nothing may be accepted
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        #3;
        chk("rst0_ready", {31'd0, if_req_ready, d_req_ready}, 33'd0);
        chk("rst0_mem_addr", {1'b0, mem_address}, 33'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        if_req_valid = 1'b0; d_req_valid = 1'b0;

        // Both ports requesting every cycle, responses always consumed
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, $urandom_range(0, 255), 1'b1, 1'b0, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, 32'd0, 1'b1, 1'b1);
            @(negedge clk); #1;
            gseq.push_back(d_req_ready ? "D" : (if_req_ready ? "F" : "-"));
        end
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            expg = (i % 2 == 0) ? "F" : "D";
`else
            expg = (i % 5 == 4) ? "F" : "D";
`endif
            chk($sformatf("grant_order[%0d]", i), {25'd0, gseq[i]}, {25'd0, expg});
        end

        // Store then load of the same word
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h78, 32'hCAFEF00D, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h78, 32'd0, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        @(negedge clk); #1;
        chk("ld_after_st", {d_resp_err, d_resp_rdata}, {1'b0, 32'hCAFEF00D});

        // Misaligned load
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h7A, 32'd0, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        @(negedge clk); #1;
        chk("misaligned", {d_resp_err, d_resp_rdata}, {1'b1, 32'd0});

        // Fetch response held while the data port keeps being served
        drive(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        dcount = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'd0, 1'b1, 1'b0, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, 32'd0, 1'b0, 1'b1);
            @(negedge clk); #1;
            dcount += int'(d_req_ready);
            chk("held_if_ready", {32'd0, if_req_ready}, 33'd0);
            chk("held_if_data", {if_resp_valid, if_resp_data}, {1'b1, 32'hDEADBEEF});
        end
        chk("data_served_while_held", 33'(dcount), 33'd3);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

        // Reset while a data response is pending, with a store presented
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk); #1;
        chk("pre_rst_d_valid", {32'd0, d_resp_valid}, 33'd1);
        keep = mem[5];
        @(posedge clk); #1;
        rst = 1'b1;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h14; d_req_wdata = ~keep;
        #1;
        chk("rst_drops_d_valid", {32'd0, d_resp_valid}, 33'd0);
        chk("rst_no_write", {32'd0, mem_write_enable}, 33'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_resp_ready = 1'b1;
        chk("rst_mem_unchanged", {1'b0, mem[5]}, {1'b0, keep});

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, {24'd0, 8'($urandom)},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  {24'd0, 6'($urandom_range(0, 63)), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00},
                  $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("drain", 33'(ifq.size() + dq.size()), 33'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
